// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, XFER} state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_W         = 9;
  localparam int DEF_BURST_MAX = 4;
  localparam int STAT_W        = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request after last_gnt, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [IW-1:0] pick,
  output logic          any_req
);

  // Scan last_gnt+1 .. last_gnt+N so the most recent winner has lowest priority.
  always_comb begin : scan
    logic          found;
    logic [IW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_gnt) + k) % N);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N producers.
// Optional per-client write counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N         = DEF_N,
  parameter  int W         = DEF_W,
  parameter  int BURST_MAX = DEF_BURST_MAX,
  localparam int GW        = $clog2(N),
  localparam int BW        = $clog2(BURST_MAX) + 1
) (
  input  logic            clk,
  input  logic            rstp,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_fullp,
  output logic            fifo_writep,
  output logic [W-1:0]    fifo_data,
  output logic [GW-1:0]   grant_id,
  output logic            busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [N*STAT_W-1:0] stat_cnt
`endif
);

  state_t          state, state_nxt;
  logic [GW-1:0]   grant_nxt, last_gnt, last_nxt, pick;
  logic [BW-1:0]   beat_cnt, beat_nxt;
  logic            busy_nxt, any_req, cur_valid;

  rr_pick #(.N(N)) u_pick (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .pick     (pick),
    .any_req  (any_req)
  );

  // Outputs are purely combinational so the FIFO write lands on the same edge as the handshake.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    last_nxt    = last_gnt;
    beat_nxt    = beat_cnt;
    busy_nxt    = busy;
    req_ready   = '0;
    fifo_writep = 1'b0;
    fifo_data   = '0;
    cur_valid   = req_valid[grant_id];
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = XFER;
          grant_nxt = pick;
          busy_nxt  = 1'b1;
          beat_nxt  = '0;
        end
      end
      XFER: begin
        req_ready[grant_id] = !fifo_fullp;
        if (!cur_valid) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
          busy_nxt  = 1'b0;
          beat_nxt  = '0;
        end else if (!fifo_fullp) begin
          fifo_writep = 1'b1;
          fifo_data   = req_data[int'(grant_id)*W +: W];
          if (beat_cnt == BW'(BURST_MAX - 1)) begin
            state_nxt = IDLE;
            last_nxt  = grant_id;
            busy_nxt  = 1'b0;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_gnt resets to N-1 so the first arbitration after reset favours client 0.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state    <= IDLE;
      grant_id <= '0;
      last_gnt <= GW'(N - 1);
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last_gnt <= last_nxt;
      beat_cnt <= beat_nxt;
      busy     <= busy_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    // Saturating count; clear takes precedence over a same-cycle write.
    always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
        cnt <= '0;
      end else if (stat_clr) begin
        cnt <= '0;
      end else if (fifo_writep && (grant_id == GW'(i)) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign stat_cnt[i*STAT_W +: STAT_W] = cnt;
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, scoreboard-checked bench for fifo_wr_arbiter (stat ports used when FIFO_ARB_STATS_EN is defined).
module tb_fifo_wr_arbiter;

  localparam int N         = 4;
  localparam int W         = 9;
  localparam int BURST_MAX = 4;
  localparam int GW        = 2;

  logic            clk;
  logic            rstp;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_fullp;
  logic            fifo_writep;
  logic [W-1:0]    fifo_data;
  logic [GW-1:0]   grant_id;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic            stat_clr;
  logic [N*16-1:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_q [N][$];
  logic [W-1:0] exp_q [$];
  logic [N-1:0] en;

  fifo_wr_arbiter #(.N(N), .W(W), .BURST_MAX(BURST_MAX)) dut (
    .clk         (clk),
    .rstp        (rstp),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_fullp  (fifo_fullp),
    .fifo_writep (fifo_writep),
    .fifo_data   (fifo_data),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_cnt    (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(int c, int k);
    return W'(256 + c * 32 + k);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each enabled client with queued words presents its head word.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = src_q[i][0];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*W +: W]   = '0;
      end
    end
  endtask

  task automatic loadWords(int c, int k0, int n, bit expect_it);
    for (int k = k0; k < k0 + n; k++) begin
      src_q[c].push_back(mk(c, k));
      if (expect_it) exp_q.push_back(mk(c, k));
    end
  endtask

  task automatic expectWords(int c, int k0, int n);
    for (int k = k0; k < k0 + n; k++) exp_q.push_back(mk(c, k));
  endtask

  // Sample one cycle mid-period, check it, then advance through the edge.
  task automatic checkOutput(string tag, bit exp_wr, bit exp_busy, int exp_gid, logic [N-1:0] exp_rdy);
    logic [N-1:0] acc;
    logic [W-1:0] e;
    #1;
    chk({tag, "/writep"}, 32'(fifo_writep), 32'(exp_wr));
    chk({tag, "/busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "/grant_id"}, 32'(grant_id), 32'(exp_gid));
    chk({tag, "/req_ready"}, 32'(req_ready), 32'(exp_rdy));
    if (fifo_writep) begin
      chk({tag, "/sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "/fifo_data"}, 32'(fifo_data), 32'(e));
      end
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    applyStimulus();
  endtask

  task automatic doReset();
    rstp = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    en = '0;
    fifo_fullp = 1'b0;
    applyStimulus();
    @(posedge clk);
    #1;
    rstp = 1'b0;
  endtask

  initial begin
    rstp       = 1'b1;
    fifo_fullp = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    en         = '0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr   = 1'b0;
`endif

    // Reset with every client valid, then one word each in round-robin order
    $display("[TB] reset and first grant");
    en = 4'b1111;
    for (int c = 0; c < N; c++) loadWords(c, 0, 1, 1'b1);
    applyStimulus();
    @(posedge clk);
    checkOutput("t1_reset", 0, 0, 0, 4'b0000);
    rstp = 1'b0;
    checkOutput("t1_idle", 0, 0, 0, 4'b0000);
    for (int g = 0; g < N; g++) begin
      checkOutput($sformatf("t1_wr%0d", g), 1, 1, g, 4'(1 << g));
      checkOutput($sformatf("t1_drop%0d", g), 0, 1, g, 4'(1 << g));
      checkOutput($sformatf("t1_idle%0d", g), 0, 0, g, 4'b0000);
    end
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Client 2 alone with 6 words: burst of 4, one idle cycle, burst of 2
    $display("[TB] burst limit");
    doReset();
    en = 4'b0100;
    loadWords(2, 0, 6, 1'b1);
    applyStimulus();
    checkOutput("t2_idle", 0, 0, 0, 4'b0000);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("t2_a%0d", k), 1, 1, 2, 4'b0100);
    checkOutput("t2_rearb", 0, 0, 2, 4'b0000);
    for (int k = 0; k < 2; k++) checkOutput($sformatf("t2_b%0d", k), 1, 1, 2, 4'b0100);
    checkOutput("t2_drop", 0, 1, 2, 4'b0100);
    checkOutput("t2_end", 0, 0, 2, 4'b0000);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // All clients always valid: grant order 0,1,2,3,0 with 4 writes per 5 cycles
    $display("[TB] fairness");
    doReset();
    en = 4'b1111;
    for (int c = 0; c < N; c++) loadWords(c, 0, 8, 1'b0);
    for (int c = 0; c < N; c++) expectWords(c, 0, 4);
    expectWords(0, 4, 4);
    applyStimulus();
    for (int b = 0; b < 5; b++) begin
      checkOutput($sformatf("t3_idle%0d", b), 0, 0, (b == 0) ? 0 : (b - 1) % N, 4'b0000);
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("t3_b%0d_w%0d", b, k), 1, 1, b % N, 4'(1 << (b % N)));
    end
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // FIFO full for 3 cycles after client 1's first word; client 2 waits its turn
    $display("[TB] backpressure");
    doReset();
    en = 4'b0110;
    loadWords(1, 0, 4, 1'b1);
    loadWords(2, 0, 1, 1'b1);
    applyStimulus();
    checkOutput("t4_idle", 0, 0, 0, 4'b0000);
    checkOutput("t4_w0", 1, 1, 1, 4'b0010);
    fifo_fullp = 1'b1;
    for (int k = 0; k < 3; k++) checkOutput($sformatf("t4_full%0d", k), 0, 1, 1, 4'b0000);
    fifo_fullp = 1'b0;
    for (int k = 1; k < 4; k++) checkOutput($sformatf("t4_w%0d", k), 1, 1, 1, 4'b0010);
    checkOutput("t4_rearb", 0, 0, 1, 4'b0000);
    checkOutput("t4_c2", 1, 1, 2, 4'b0100);
    checkOutput("t4_c2drop", 0, 1, 2, 4'b0100);
    checkOutput("t4_end", 0, 0, 2, 4'b0000);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Client 3 ends early after 2 words; waiting client 0 is granted next
    $display("[TB] early release");
    doReset();
    en = 4'b1000;
    loadWords(3, 0, 2, 1'b1);
    loadWords(0, 0, 2, 1'b1);
    applyStimulus();
    checkOutput("t5_idle", 0, 0, 0, 4'b0000);
    en[0] = 1'b1;
    applyStimulus();
    checkOutput("t5_c3w0", 1, 1, 3, 4'b1000);
    checkOutput("t5_c3w1", 1, 1, 3, 4'b1000);
    checkOutput("t5_c3drop", 0, 1, 3, 4'b1000);
    checkOutput("t5_rearb", 0, 0, 3, 4'b0000);
    checkOutput("t5_c0w0", 1, 1, 0, 4'b0001);
    checkOutput("t5_c0w1", 1, 1, 0, 4'b0001);
    checkOutput("t5_c0drop", 0, 1, 0, 4'b0001);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Async reset pulsed while client 1 presents its third word
    $display("[TB] async reset mid-burst");
    doReset();
    en = 4'b0010;
    loadWords(1, 0, 4, 1'b0);
    expectWords(1, 0, 2);
    applyStimulus();
    checkOutput("t6_idle", 0, 0, 0, 4'b0000);
    checkOutput("t6_w0", 1, 1, 1, 4'b0010);
    checkOutput("t6_w1", 1, 1, 1, 4'b0010);
    #1;
    chk("t6_pre_writep", 32'(fifo_writep), 32'd1);
    rstp = 1'b1;
    #1;
    chk("t6_rst_writep", 32'(fifo_writep), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_grant", 32'(grant_id), 32'd0);
    chk("t6_rst_data", 32'(fifo_data), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    chk("t6_rst_stat1", 32'(stat_cnt[16 +: 16]), 32'd0);
`endif
    #1;
    rstp = 1'b0;
    en[0] = 1'b1;
    loadWords(0, 0, 2, 1'b1);
    expectWords(1, 2, 2);
    applyStimulus();
    checkOutput("t6_idle2", 0, 0, 0, 4'b0000);
    checkOutput("t6_c0w0", 1, 1, 0, 4'b0001);
    checkOutput("t6_c0w1", 1, 1, 0, 4'b0001);
    checkOutput("t6_c0drop", 0, 1, 0, 4'b0001);
    checkOutput("t6_rearb", 0, 0, 0, 4'b0000);
    checkOutput("t6_c1w2", 1, 1, 1, 4'b0010);
    checkOutput("t6_c1w3", 1, 1, 1, 4'b0010);
    checkOutput("t6_c1drop", 0, 1, 1, 4'b0010);
    checkOutput("t6_end", 0, 0, 1, 4'b0000);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
